writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
Final datapath stage that feeds the 8x16 register file's write port (write, writeAdd, in). Accepts one completed instruction result per handshake from the execute stage. Picks the ALU, PC-link or memory-load value and formats byte loads. Waits for late load data, then issues a single-cycle registered write pulse and updates the NZP condition-code register.

Parameters:
DATA_W, 16, datapath width; the register file and data formatting are defined for 16 only.
ADDR_W, 3, register index width (8 registers).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream result/op valid
in_ready  output  1  stage can accept an op this cycle
in_src  input  2  0=ALU, 1=PC link, 2=MEM load, 3=reserved (treated as ALU)
in_dest  input  ADDR_W  destination register
in_wen  input  1  op writes a register
in_setcc  input  1  op updates NZP
in_byte  input  1  MEM op is a byte load (LDB)
in_addr_lsb  input  1  byte select for LDB
alu_result  input  DATA_W  ALU result
pc_link  input  DATA_W  link value (PC+2)
mem_data  input  DATA_W  load data from memory
mem_valid  input  1  mem_data valid this cycle
rf_write  output  1  register-file write enable (one-cycle pulse)
rf_writeAdd  output  ADDR_W  register-file write address
rf_data  output  DATA_W  register-file write data
nzp  output  3  condition codes {N,Z,P}
mem_err  output  1  sticky: mem_valid seen while no load pending

Behaviour:
- The FSM has two states: IDLE and WAIT_MEM.
- in_ready is combinational: 1 in IDLE, 0 in WAIT_MEM.
- An op is accepted on a rising edge with in_valid & in_ready.
- IDLE, accept of an ALU/PC/reserved op:
  - rf_write<=in_wen, rf_writeAdd<=in_dest, rf_data<=selected value.
  - Stay in IDLE. Latency is 1 cycle; throughput is 1 op/cycle back-to-back.
- IDLE, accept of a MEM op:
  - Latch dest, wen, setcc, byte and lsb; go to WAIT_MEM.
  - rf_write<=0.
- WAIT_MEM with mem_valid=1:
  - Format the data, commit it on the next edge (rf_write<=latched wen) and return to IDLE.
  - Commit is 1 cycle after mem_valid.
  - mem_valid in the same cycle as the accept of the MEM op is not consumed; only WAIT_MEM cycles count.
- WAIT_MEM with mem_valid=0: hold; rf_write<=0; in_ready=0.
- In every cycle with no commit, rf_write<=0. rf_writeAdd and rf_data hold their last committed values.
- Byte format:
  - lsb=0 selects mem_data[7:0]; lsb=1 selects mem_data[15:8].
  - The byte is sign-extended to 16 bits.
  - A word load passes mem_data unchanged.
- NZP:
  - Updates on the commit edge only if setcc, independent of wen.
  - N=data[15]; Z=(data==0); P=otherwise. Exactly one bit is set.
- mem_err sets when mem_valid=1 in IDLE and clears only on reset.
- Reset (async, any state, including mid-load):
  - state=IDLE, the pending load is dropped, and rf_write=0.
  - rf_writeAdd=0, rf_data=0, nzp=3'b010, mem_err=0.
  - The first accept is possible in the first cycle after reset deasserts.

Optional Feature:
WB_BYPASS_EN:
- When defined, add outputs fwd_valid(1), fwd_dest(ADDR_W) and fwd_data(DATA_W), all combinational.
- fwd_valid=1 in IDLE when in_valid&in_wen and src≠MEM, or in WAIT_MEM when mem_valid&latched wen.
- fwd_dest/fwd_data carry the value that will commit on the next edge, so decode can bypass the register file a cycle early.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then an ALU op (dest=3, alu_result=16'h8001, wen=1, setcc=1) -> next cycle rf_write=1, rf_writeAdd=3, rf_data=16'h8001, nzp=3'b100; following cycle rf_write=0.
- Back-to-back ALU ops on dest 1,2,3 with values 5,0,7 on consecutive cycles -> three consecutive rf_write pulses; nzp sequence 001, 010, 001.
- LDB, lsb=1, dest=5; mem_valid asserted 3 cycles later with mem_data=16'hF27A -> in_ready=0 throughout the wait; rf_data=16'hFFF2 one cycle after mem_valid; nzp=100.
- Word load with mem_data=16'h0000, wen=1, setcc=1 -> rf_data=0, nzp=010; a PC-link op (pc_link=16'h3002, setcc=0, dest=7) then commits 3002 with nzp unchanged.
- Reset asserted while in WAIT_MEM, then mem_valid pulse after release -> no rf_write, mem_err=1, nzp=010.
- With WB_BYPASS_EN: ALU op dest=4 value 16'h1234 -> fwd_valid=1, fwd_dest=4, fwd_data=1234 in the accept cycle; rf_write the cycle after.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects the ALU, PC-link or load result, waits for late load data, and drives the register-file write port and NZP.
// Optional macro WB_BYPASS_EN adds combinational forwarding outputs (fwd_valid/fwd_dest/fwd_data).
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_src,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wen,
  input  logic              in_setcc,
  input  logic              in_byte,
  input  logic              in_addr_lsb,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_link,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_writeAdd,
  output logic [DATA_W-1:0] rf_data,
  output logic [2:0]        nzp,
  output logic              mem_err
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // state    | meaning
  // IDLE     | accepting ops; ALU/PC ops commit on the accept edge
  // WAIT_MEM | load accepted, holding its control until mem_valid arrives
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  localparam logic [1:0] SRC_PC  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  logic [0:0]        state;
  logic [ADDR_W-1:0] lat_dest;
  logic              lat_wen;
  logic              lat_setcc;
  logic              lat_byte;
  logic              lat_lsb;

  logic              accept;
  logic              accept_mem;
  logic              commit_en;
  logic              commit_wen;
  logic              commit_setcc;
  logic [ADDR_W-1:0] commit_dest;
  logic [DATA_W-1:0] commit_data;

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] d,
                                                 input logic              byte_ld,
                                                 input logic              lsb);
    logic [7:0] b;
    b = lsb ? d[15:8] : d[7:0];
    return byte_ld ? {{(DATA_W-8){b[7]}}, b} : d;
  endfunction

  function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])  return 3'b100;
    else if (d == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign accept_mem = accept & (in_src == SRC_MEM);

  // One place describes "what commits on the next edge"; the registers and the bypass both use it.
  always_comb begin
    commit_en    = 1'b0;
    commit_wen   = 1'b0;
    commit_setcc = 1'b0;
    commit_dest  = '0;
    commit_data  = '0;
    if (state == IDLE) begin
      commit_en    = accept & ~accept_mem;
      commit_wen   = in_wen;
      commit_setcc = in_setcc;
      commit_dest  = in_dest;
      commit_data  = (in_src == SRC_PC) ? pc_link : alu_result;
    end else begin
      commit_en    = mem_valid;
      commit_wen   = lat_wen;
      commit_setcc = lat_setcc;
      commit_dest  = lat_dest;
      commit_data  = fmt_load(mem_data, lat_byte, lat_lsb);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_dest    <= '0;
      lat_wen     <= 1'b0;
      lat_setcc   <= 1'b0;
      lat_byte    <= 1'b0;
      lat_lsb     <= 1'b0;
      rf_write    <= 1'b0;
      rf_writeAdd <= '0;
      rf_data     <= '0;
      nzp         <= 3'b010;
      mem_err     <= 1'b0;
    end else begin
      rf_write <= 1'b0;
      if (state == IDLE && mem_valid) mem_err <= 1'b1;

      if (accept_mem) begin
        lat_dest  <= in_dest;
        lat_wen   <= in_wen;
        lat_setcc <= in_setcc;
        lat_byte  <= in_byte;
        lat_lsb   <= in_addr_lsb;
        state     <= WAIT_MEM;
      end else if (state == WAIT_MEM && mem_valid) begin
        state <= IDLE;
      end

      if (commit_en) begin
        rf_write    <= commit_wen;
        rf_writeAdd <= commit_dest;
        rf_data     <= commit_data;
        if (commit_setcc) nzp <= cc_of(commit_data);
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = commit_en & commit_wen;
  assign fwd_dest  = commit_dest;
  assign fwd_data  = commit_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written load/reset sequences and a randomized run against a transaction-level model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_src;
  logic [2:0]  in_dest;
  logic        in_wen;
  logic        in_setcc;
  logic        in_byte;
  logic        in_addr_lsb;
  logic [15:0] alu_result;
  logic [15:0] pc_link;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        rf_write;
  logic [2:0]  rf_writeAdd;
  logic [15:0] rf_data;
  logic [2:0]  nzp;
  logic        mem_err;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [2:0]  fwd_dest;
  logic [15:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_dest(in_dest),
    .in_wen(in_wen), .in_setcc(in_setcc), .in_byte(in_byte), .in_addr_lsb(in_addr_lsb),
    .alu_result(alu_result), .pc_link(pc_link), .mem_data(mem_data), .mem_valid(mem_valid),
    .rf_write(rf_write), .rf_writeAdd(rf_writeAdd), .rf_data(rf_data), .nzp(nzp), .mem_err(mem_err)
`ifdef WB_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  dest;
    logic        wen;
    logic        setcc;
    logic [15:0] alu;
    logic [15:0] pc;
    logic        exp_write;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic [2:0]  exp_nzp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] src, input logic [2:0] dest, input logic wen,
                        input logic setcc, input logic byt, input logic lsb,
                        input logic [15:0] alu, input logic [15:0] pc);
    in_valid    = 1'b1;
    in_src      = src;
    in_dest     = dest;
    in_wen      = wen;
    in_setcc    = setcc;
    in_byte     = byt;
    in_addr_lsb = lsb;
    alu_result  = alu;
    pc_link     = pc;
  endtask

  function automatic logic [22:0] wb_out(input logic w, input logic [2:0] a,
                                         input logic [15:0] d, input logic [2:0] cc);
    return {w, a, d, cc};
  endfunction

  // Reference rules, written straight from the stage's behaviour.
  function automatic logic [15:0] ref_load(input logic [15:0] d, input logic byt, input logic lsb);
    int b;
    if (!byt) return d;
    b = lsb ? int'(d) / 256 : int'(d) % 256;
    if (b >= 128) b = b - 256;
    return 16'(b);
  endfunction

  function automatic logic [2:0] ref_cc(input logic [15:0] d);
    if (d >= 16'h8000) return 3'b100;
    if (d == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  // Model state for the random run
  bit          m_pend;
  logic [2:0]  p_dest;
  logic        p_wen, p_setcc, p_byte, p_lsb;
  logic        m_write;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  logic [2:0]  m_nzp;

  task automatic model_commit(input logic wen, input logic [2:0] dest, input logic setcc,
                              input logic [15:0] value);
    m_write = wen;
    m_addr  = dest;
    m_data  = value;
    if (setcc) m_nzp = ref_cc(value);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_src = 2'd0; in_dest = 3'd0; in_wen = 1'b0; in_setcc = 1'b0;
    in_byte = 1'b0; in_addr_lsb = 1'b0; alu_result = '0; pc_link = '0;
    mem_data = '0; mem_valid = 1'b0;

    //            src   dst  wen  scc  alu       pc        w    addr  data      nzp
    vecs[0] = '{2'd0, 3'd3, 1'b1, 1'b1, 16'h8001, 16'h0000, 1'b1, 3'd3, 16'h8001, 3'b100};
    vecs[1] = '{2'd0, 3'd1, 1'b1, 1'b1, 16'h0005, 16'h0000, 1'b1, 3'd1, 16'h0005, 3'b001};
    vecs[2] = '{2'd0, 3'd2, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 3'd2, 16'h0000, 3'b010};
    vecs[3] = '{2'd0, 3'd3, 1'b1, 1'b1, 16'h0007, 16'h0000, 1'b1, 3'd3, 16'h0007, 3'b001};
    vecs[4] = '{2'd1, 3'd7, 1'b1, 1'b0, 16'h9999, 16'h3002, 1'b1, 3'd7, 16'h3002, 3'b001};
    vecs[5] = '{2'd3, 3'd6, 1'b0, 1'b1, 16'hFFFF, 16'h1111, 1'b0, 3'd6, 16'hFFFF, 3'b100};
    vecs[6] = '{2'd0, 3'd0, 1'b1, 1'b0, 16'h1234, 16'h2222, 1'b1, 3'd0, 16'h1234, 3'b100};

    repeat (2) tick();
    check("reset_outputs", {wb_out(rf_write, rf_writeAdd, rf_data, nzp), mem_err},
          {wb_out(1'b0, 3'd0, 16'h0000, 3'b010), 1'b0});
    check("reset_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Back-to-back single-cycle ops, one per clock
    for (int i = 0; i < 7; i++) begin
      set_op(vecs[i].src, vecs[i].dest, vecs[i].wen, vecs[i].setcc, 1'b0, 1'b0,
             vecs[i].alu, vecs[i].pc);
      tick();
      check($sformatf("vec%0d", i), wb_out(rf_write, rf_writeAdd, rf_data, nzp),
            wb_out(vecs[i].exp_write, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_nzp));
    end
    in_valid = 1'b0;
    tick();
    check("idle_hold", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b0, 3'd0, 16'h1234, 3'b100));

`ifdef WB_BYPASS_EN
    set_op(2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
    #1;
    check("fwd_accept", {fwd_valid, fwd_dest, fwd_data}, {1'b1, 3'd4, 16'h1234});
    tick();
    in_valid = 1'b0;
    check("fwd_commit", {rf_write, rf_writeAdd, rf_data}, {1'b1, 3'd4, 16'h1234});
`endif

    // LDB high byte, data three cycles late; a competing op must not be accepted
    set_op(2'd2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    #1;
    check("ldb_accept_ready", in_ready, 1'b1);
    tick();
    set_op(2'd0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ldb_wait%0d", i), {in_ready, rf_write}, 2'b00);
      tick();
    end
    mem_valid = 1'b1;
    mem_data  = 16'hF27A;
    #1;
    check("ldb_ready_at_data", in_ready, 1'b0);
    tick();
    in_valid = 1'b0; mem_valid = 1'b0;
    check("ldb_hi_commit", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b1, 3'd5, 16'hFFF2, 3'b100));
    check("ldb_ready_after", in_ready, 1'b1);
    tick();
    check("ldb_no_second_write", rf_write, 1'b0);

    // Word load of zero, then PC link without setcc
    set_op(2'd2, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0; mem_valid = 1'b1; mem_data = 16'h0000;
    tick();
    mem_valid = 1'b0;
    check("ldw_zero", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b1, 3'd4, 16'h0000, 3'b010));
    set_op(2'd1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h3002);
    tick();
    in_valid = 1'b0;
    check("pc_link_no_cc", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b1, 3'd7, 16'h3002, 3'b010));

    // LDB low byte, positive; then LDB low byte negative with wen=0 but setcc=1
    set_op(2'd2, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0; mem_valid = 1'b1; mem_data = 16'h807F;
    tick();
    mem_valid = 1'b0;
    check("ldb_lo_pos", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b1, 3'd1, 16'h007F, 3'b001));
    set_op(2'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0; mem_valid = 1'b1; mem_data = 16'h1280;
    tick();
    mem_valid = 1'b0;
    check("ldb_lo_neg_nowen", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b0, 3'd2, 16'hFF80, 3'b100));

    // mem_valid in the accept cycle is not consumed
    set_op(2'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    mem_valid = 1'b1; mem_data = 16'hAAAA;
    tick();
    in_valid = 1'b0; mem_valid = 1'b0;
    check("same_cycle_not_used", {in_ready, rf_write}, 2'b00);
    tick();
    check("same_cycle_still_wait", {in_ready, rf_write}, 2'b00);
    mem_valid = 1'b1; mem_data = 16'h0001;
    tick();
    mem_valid = 1'b0;
    check("same_cycle_commit", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b1, 3'd3, 16'h0001, 3'b100));

    // Async reset while a load is pending
    set_op(2'd2, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_mid_load", {wb_out(rf_write, rf_writeAdd, rf_data, nzp), mem_err, in_ready},
          {wb_out(1'b0, 3'd0, 16'h0000, 3'b010), 1'b0, 1'b1});
    tick();
    reset = 1'b0;
    mem_valid = 1'b1; mem_data = 16'h1234;
    tick();
    mem_valid = 1'b0;
    check("dropped_load", {rf_write, mem_err, nzp, in_ready}, {1'b0, 1'b1, 3'b010, 1'b1});

    // First accept right after reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_cleared", mem_err, 1'b0);
    set_op(2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000);
    tick();
    in_valid = 1'b0;
    check("first_after_reset", wb_out(rf_write, rf_writeAdd, rf_data, nzp),
          wb_out(1'b1, 3'd2, 16'h0042, 3'b001));

    // Randomized run against the model
    m_pend = 1'b0; m_write = 1'b0; m_addr = 3'd2; m_data = 16'h0042; m_nzp = 3'b001;
    p_dest = '0; p_wen = 1'b0; p_setcc = 1'b0; p_byte = 1'b0; p_lsb = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic exp_fwd;
      logic [15:0] val;
      set_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      mem_valid = m_pend && ($urandom_range(0, 2) == 0);
      mem_data  = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      #1;
      check("rand_ready", in_ready, !m_pend);
      exp_fwd = m_pend ? (mem_valid && p_wen) : (in_valid && in_wen && in_src != 2'd2);
`ifdef WB_BYPASS_EN
      check("rand_fwd_valid", fwd_valid, exp_fwd);
`endif
      m_write = 1'b0;
      if (m_pend) begin
        if (mem_valid) begin
          model_commit(p_wen, p_dest, p_setcc, ref_load(mem_data, p_byte, p_lsb));
          m_pend = 1'b0;
        end
      end else if (in_valid) begin
        if (in_src == 2'd2) begin
          m_pend = 1'b1;
          p_dest = in_dest; p_wen = in_wen; p_setcc = in_setcc;
          p_byte = in_byte; p_lsb = in_addr_lsb;
        end else begin
          val = (in_src == 2'd1) ? pc_link : alu_result;
          model_commit(in_wen, in_dest, in_setcc, val);
        end
      end
`ifdef WB_BYPASS_EN
      if (exp_fwd) check("rand_fwd_payload", {fwd_dest, fwd_data}, {m_addr, m_data});
`endif
      tick();
      check($sformatf("rand_cyc%0d", cyc), wb_out(rf_write, rf_writeAdd, rf_data, nzp),
            wb_out(m_write, m_addr, m_data, m_nzp));
    end
    in_valid = 1'b0; mem_valid = 1'b0;
    check("rand_no_mem_err", mem_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
